// File: rtl/grv_mem_pkg.sv
// Shared types for the two-port memory arbiter.
//   arb_state_e : arbiter FSM states (IDLE / ISSUE / WAIT)
//   req_id_t    : requester ID, REQ_FETCH = 0, REQ_LSU = 1
//   len_t       : burst length field (beats minus 1)
//   id_to_onehot: requester ID to 2-bit one-hot strobe
package grv_mem_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2
  } arb_state_e;

  typedef logic req_id_t;

  localparam req_id_t REQ_FETCH = 1'b0;
  localparam req_id_t REQ_LSU   = 1'b1;

  typedef logic [2:0] len_t;

  function automatic logic [1:0] id_to_onehot(input req_id_t id);
    return (id == REQ_LSU) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin grant with its own priority pointer.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req_i         : request vector (bit0 fetch, bit1 LSU)
//   en_i          : a grant may be issued this cycle; pointer moves only when it is
//   gnt_o         : one-hot grant (zero when disabled or no request)
//   gnt_id_o      : ID of the requester that would win
module mem_arb_rr
  import grv_mem_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o,
  output req_id_t    gnt_id_o
);

  // ptr_q names the requester that wins a tie.
  req_id_t ptr_q, ptr_d;
  logic    take;

  always_comb begin
    take     = en_i && (|req_i);
    gnt_id_o = (req_i == 2'b11) ? ptr_q : (req_i[1] ? REQ_LSU : REQ_FETCH);
    gnt_o    = take ? id_to_onehot(gnt_id_o) : 2'b00;
    ptr_d    = ptr_q;
    // The loser of this grant gets priority next time.
    if (take) begin
      ptr_d = ~gnt_id_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= REQ_FETCH;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch, LSU) arbiter in front of a single-outstanding memory port.
// One transaction at a time: IDLE grants round-robin and latches the request, ISSUE
// holds it on the memory port until accepted, WAIT forwards response beats
// combinationally to the owner until the last beat.
// Optional feature: define MEM_ARBITER_TIMEOUT_EN to add a WAIT watchdog that, after
// TIMEOUT_CYC cycles without a beat, returns a zero last-beat to the owner and sets err.
// Ports:
//   clock, reset (async, active low)
//   req_valid/req_ready/req_addr/req_wen/req_wdata/req_len : packed per requester
//   rsp_valid[1:0], rsp_data, rsp_last                     : response to requesters
//   mem_req_* / mem_rsp_*                                  : memory side
//   err                                                    : sticky timeout flag
module mem_arbiter
  import grv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [1:0]          req_wen,
  input  logic [2*DATA_W-1:0] req_wdata,
  input  logic [5:0]          req_len,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_last,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [2:0]          mem_req_len,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data,
  input  logic                mem_rsp_last,
  output logic                err
);

  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT_CYC must be nonzero");
  end

  arb_state_e          state_q, state_d;
  req_id_t             owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  len_t                len_q, len_d;
  logic [1:0]          gnt;
  req_id_t             gnt_id;

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  mem_arb_rr u_rr (
    .clk_i    (clock),
    .rst_ni   (reset),
    .req_i    (req_valid),
    .en_i     (state_q == StIdle),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  // Grant is combinational from req_valid, so mask it while reset is held.
  assign req_ready     = gnt & {2{reset}};
  assign mem_req_valid = (state_q == StIssue);
  assign mem_req_addr  = addr_q;
  assign mem_req_wen   = wen_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_len   = len_q;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    wen_d     = wen_q;
    wdata_d   = wdata_q;
    len_d     = len_q;
    rsp_valid = 2'b00;
    rsp_data  = '0;
    rsp_last  = 1'b0;
`ifdef MEM_ARBITER_TIMEOUT_EN
    cnt_d     = '0;
    err_d     = err_q;
`endif
    case (state_q)
      StIdle: begin
        if (|req_valid) begin
          owner_d = gnt_id;
          if (gnt_id == REQ_LSU) begin
            addr_d  = req_addr[2*ADDR_W-1:ADDR_W];
            wen_d   = req_wen[1];
            wdata_d = req_wdata[2*DATA_W-1:DATA_W];
            len_d   = req_len[5:3];
          end else begin
            addr_d  = req_addr[ADDR_W-1:0];
            wen_d   = req_wen[0];
            wdata_d = req_wdata[DATA_W-1:0];
            len_d   = req_len[2:0];
          end
          // Writes are always a single beat.
          if (wen_d) begin
            len_d = '0;
          end
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (mem_req_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (mem_rsp_valid) begin
          rsp_valid = id_to_onehot(owner_q);
          rsp_data  = mem_rsp_data;
          rsp_last  = mem_rsp_last;
          if (mem_rsp_last) begin
            state_d = StIdle;
          end
        end
`ifdef MEM_ARBITER_TIMEOUT_EN
        else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
          // Synthesize a terminating zero beat so the owner is not left hanging.
          rsp_valid = id_to_onehot(owner_q);
          rsp_last  = 1'b1;
          err_d     = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`endif
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      owner_q <= REQ_FETCH;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      len_q   <= len_d;
    end
  end

`ifdef MEM_ARBITER_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic         clock;
  logic         reset;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [63:0]  req_addr;
  logic [1:0]   req_wen;
  logic [127:0] req_wdata;
  logic [5:0]   req_len;
  logic [1:0]   rsp_valid;
  logic [63:0]  rsp_data;
  logic         rsp_last;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [31:0]  mem_req_addr;
  logic         mem_req_wen;
  logic [63:0]  mem_req_wdata;
  logic [2:0]   mem_req_len;
  logic         mem_rsp_valid;
  logic [63:0]  mem_rsp_data;
  logic         mem_rsp_last;
  logic         err;

  typedef struct {
    logic [1:0]  v;
    logic [63:0] d;
    logic        l;
  } beat_t;

  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;

  mem_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (64),
    .TIMEOUT_CYC (8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_wen       (req_wen),
    .req_wdata     (req_wdata),
    .req_len       (req_len),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_last      (rsp_last),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wen   (mem_req_wen),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_len   (mem_req_len),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .mem_rsp_last  (mem_rsp_last),
    .err           (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid     = '0;
    req_addr      = '0;
    req_wen       = '0;
    req_wdata     = '0;
    req_len       = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    mem_rsp_last  = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic set_req(input int idx, input logic [31:0] a, input logic w,
                         input logic [63:0] wd, input logic [2:0] l);
    req_valid[idx]          = 1'b1;
    req_addr[idx*32 +: 32]  = a;
    req_wen[idx]            = w;
    req_wdata[idx*64 +: 64] = wd;
    req_len[idx*3 +: 3]     = l;
  endtask

  // Memory side: accept the pending request once it shows up (bounded wait).
  task automatic mem_accept();
    int n = 0;
    while (mem_req_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (mem_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL mem_req_wait: mem_req_valid=%b after %0d cycles, required 1", mem_req_valid, n);
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
  endtask

  // Drive beats [first, first+count) of a total-beat burst; expected response pushed on
  // drive and popped/compared in the same cycle since forwarding is combinational.
  task automatic mem_beats(input logic [1:0] own, input int first, input int count,
                           input int total, input logic [63:0] base);
    beat_t e;
    beat_t got;
    for (int b = 0; b < count; b++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = base + 64'(first + b);
      mem_rsp_last  = (first + b == total - 1);
      e.v = own;
      e.d = mem_rsp_data;
      e.l = mem_rsp_last;
      sb.push_back(e);
      @(negedge clock);
      got = sb.pop_front();
      checks++;
      if (rsp_valid !== got.v || rsp_data !== got.d || rsp_last !== got.l) begin
        errors++;
        $display("FAIL beat%0d: got v=%b d=%h l=%b, required v=%b d=%h l=%b",
                 first + b, rsp_valid, rsp_data, rsp_last, got.v, got.d, got.l);
      end
      tick();
    end
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    mem_rsp_last  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    req_valid     = 2'b11;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'hFFFF_0000_FFFF_0000;
    mem_rsp_last  = 1'b1;
    @(negedge clock);
    checks++;
    if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || rsp_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: got rr=%b rv=%b rl=%b, required 00 00 0",
               req_ready, rsp_valid, rsp_last);
    end
    checks++;
    if (mem_req_valid !== 1'b0 || rsp_data !== 64'h0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: got mv=%b rd=%h err=%b, required 0 0 0",
               mem_req_valid, rsp_data, err);
    end
    checks++;
    if (mem_req_addr !== 32'h0 || mem_req_wen !== 1'b0 || mem_req_wdata !== 64'h0 ||
        mem_req_len !== 3'h0) begin
      errors++;
      $display("FAIL reset_fields: got a=%h w=%b d=%h l=%h, required all 0",
               mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_len);
    end
    @(posedge clock);
    #1 reset = 1'b1;
    clear_inputs();
    @(negedge clock);
    checks++;
    if (req_ready !== 2'b00 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got rr=%b mv=%b, required 00 0", req_ready, mem_req_valid);
    end
    tick();
  endtask

  task automatic test_fetch_read();
    set_req(0, 32'h1000, 1'b0, 64'h0, 3'd3);
    @(negedge clock);
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL fetch_grant: got req_ready=%b, required 01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    @(negedge clock);
    checks++;
    if (req_ready !== 2'b00 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h1000 ||
        mem_req_len !== 3'd3 || mem_req_wen !== 1'b0) begin
      errors++;
      $display("FAIL fetch_issue: got rr=%b mv=%b a=%h l=%0d w=%b, required 00 1 1000 3 0",
               req_ready, mem_req_valid, mem_req_addr, mem_req_len, mem_req_wen);
    end
    mem_accept();
    mem_beats(2'b01, 0, 4, 4, 64'hA000);
    @(negedge clock);
    checks++;
    if (mem_req_valid !== 1'b0 || rsp_valid !== 2'b00 || sb.size() != 0) begin
      errors++;
      $display("FAIL fetch_done: got mv=%b rv=%b sb=%0d, required 0 00 0",
               mem_req_valid, rsp_valid, sb.size());
    end
    tick();
  endtask

  task automatic test_round_robin();
    apply_reset();
    set_req(0, 32'h1100, 1'b0, 64'h0, 3'd1);
    set_req(1, 32'h2100, 1'b0, 64'h0, 3'd0);
    @(negedge clock);
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL rr_first: got req_ready=%b, required 01", req_ready);
    end
    tick();
    req_valid[0] = 1'b0;
    @(negedge clock);
    checks++;
    if (req_ready !== 2'b00 || mem_req_addr !== 32'h1100) begin
      errors++;
      $display("FAIL rr_busy: got rr=%b a=%h, required 00 1100", req_ready, mem_req_addr);
    end
    mem_accept();
    mem_beats(2'b01, 0, 2, 2, 64'hB000);
    // Fetch re-requests in the turnaround IDLE; LSU must win.
    req_valid[0] = 1'b1;
    @(negedge clock);
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL rr_lsu_turn: got req_ready=%b, required 10", req_ready);
    end
    tick();
    req_valid[1] = 1'b0;
    @(negedge clock);
    checks++;
    if (mem_req_addr !== 32'h2100 || mem_req_len !== 3'd0 || req_ready !== 2'b00) begin
      errors++;
      $display("FAIL rr_lsu_issue: got a=%h l=%0d rr=%b, required 2100 0 00",
               mem_req_addr, mem_req_len, req_ready);
    end
    mem_accept();
    mem_beats(2'b10, 0, 1, 1, 64'hC000);
    @(negedge clock);
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL rr_fetch_back: got req_ready=%b, required 01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    mem_accept();
    mem_beats(2'b01, 0, 2, 2, 64'hD000);
  endtask

  task automatic test_write();
    set_req(1, 32'h2000, 1'b1, 64'hDEADBEEF, 3'd5);
    @(negedge clock);
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL wr_grant: got req_ready=%b, required 10", req_ready);
    end
    tick();
    req_valid = 2'b00;
    @(negedge clock);
    checks++;
    if (mem_req_wen !== 1'b1 || mem_req_len !== 3'd0 || mem_req_addr !== 32'h2000 ||
        mem_req_wdata !== 64'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_issue: got w=%b l=%0d a=%h d=%h, required 1 0 2000 deadbeef",
               mem_req_wen, mem_req_len, mem_req_addr, mem_req_wdata);
    end
    mem_accept();
    mem_beats(2'b10, 0, 1, 1, 64'h0);
  endtask

  task automatic test_stall();
    int bad = 0;
    set_req(0, 32'h3000, 1'b0, 64'h0, 3'd1);
    tick();
    req_valid = 2'b00;
    for (int i = 0; i < 10; i++) begin
      mem_rsp_valid = (i % 3 == 0);
      mem_rsp_data  = 64'h5555_0000 + 64'(i);
      mem_rsp_last  = 1'b1;
      @(negedge clock);
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h3000 || mem_req_len !== 3'd1 ||
          mem_req_wen !== 1'b0 || rsp_valid !== 2'b00) begin
        errors++;
        bad++;
        $display("FAIL stall_hold%0d: got mv=%b a=%h l=%0d w=%b rv=%b, required 1 3000 1 0 00",
                 i, mem_req_valid, mem_req_addr, mem_req_len, mem_req_wen, rsp_valid);
      end
      tick();
    end
    clear_inputs();
    mem_accept();
    mem_beats(2'b01, 0, 2, 2, 64'hE000);
    for (int i = 0; i < 3; i++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_last  = (i == 2);
      mem_rsp_data  = 64'h7777;
      @(negedge clock);
      checks++;
      if (rsp_valid !== 2'b00 || rsp_last !== 1'b0) begin
        errors++;
        $display("FAIL idle_spurious%0d: got rv=%b rl=%b, required 00 0", i, rsp_valid, rsp_last);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    set_req(0, 32'h4000, 1'b0, 64'h0, 3'd3);
    tick();
    req_valid = 2'b00;
    mem_accept();
    mem_beats(2'b01, 0, 2, 4, 64'hF000);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'hF002;
    reset = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 2'b00 || rsp_data !== 64'h0 || rsp_last !== 1'b0 ||
        mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: got rv=%b rd=%h rl=%b mv=%b a=%h, required all 0",
               rsp_valid, rsp_data, rsp_last, mem_req_valid, mem_req_addr);
    end
    @(posedge clock);
    #1 reset = 1'b1;
    mem_rsp_data = 64'hF003;
    mem_rsp_last = 1'b1;
    @(negedge clock);
    checks++;
    if (rsp_valid !== 2'b00 || rsp_last !== 1'b0 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_late_beat: got rv=%b rl=%b mv=%b, required 00 0 0",
               rsp_valid, rsp_last, mem_req_valid);
    end
    tick();
    clear_inputs();
  endtask

`ifdef MEM_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    beat_t e;
    beat_t got;
    set_req(0, 32'h5000, 1'b0, 64'h0, 3'd0);
    tick();
    req_valid = 2'b00;
    mem_accept();
    for (int k = 1; k <= 8; k++) begin
      if (k == 8) begin
        e.v = 2'b01;
        e.d = 64'h0;
        e.l = 1'b1;
        sb.push_back(e);
      end
      @(negedge clock);
      checks++;
      if (k < 8) begin
        if (rsp_valid !== 2'b00 || err !== 1'b0) begin
          errors++;
          $display("FAIL to_early%0d: got rv=%b err=%b, required 00 0", k, rsp_valid, err);
        end
      end else begin
        got = sb.pop_front();
        if (rsp_valid !== got.v || rsp_data !== got.d || rsp_last !== got.l) begin
          errors++;
          $display("FAIL to_pulse: got v=%b d=%h l=%b, required v=%b d=%h l=%b",
                   rsp_valid, rsp_data, rsp_last, got.v, got.d, got.l);
        end
      end
      tick();
    end
    repeat (3) begin
      @(negedge clock);
      checks++;
      if (err !== 1'b1 || mem_req_valid !== 1'b0 || rsp_valid !== 2'b00) begin
        errors++;
        $display("FAIL to_sticky: got err=%b mv=%b rv=%b, required 1 0 00",
                 err, mem_req_valid, rsp_valid);
      end
      tick();
    end
    apply_reset();
    @(negedge clock);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL to_clear: got err=%b, required 0", err);
    end
    tick();
  endtask
`endif

  initial begin
    reset = 1'b0;
    clear_inputs();
    test_reset();
    test_fetch_read();
    test_round_robin();
    test_write();
    test_stall();
    test_reset_mid();
`ifdef MEM_ARBITER_TIMEOUT_EN
    test_timeout();
`endif
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
